// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the uart echo controller.
//   byte_t      : one uart data byte
//   tx_state_e  : transmit sequencer states
//   ASCII_CR/LF : line-ending bytes used by the optional CR->CRLF expansion
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_ACK,
        RETRY,
        WAIT_DONE
    } tx_state_e;

    localparam byte_t ASCII_CR = 8'h0D;
    localparam byte_t ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// uart_echo_ctrl_if
// Bundles the receiver/transmitter handshake and the status outputs of the
// echo controller.
//   slave  : controller side (rx_data, rx_busy, tx_busy in; tx_data, tx_wr,
//            last_rx, fill, overflow out)
//   master : environment side (uart model or test bench)
// Parameter AW sizes fill (AW+1 bits, 0..DEPTH).
interface uart_echo_ctrl_if #(parameter int AW = 3);

    logic [7:0]  rx_data;
    logic        rx_busy;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic [7:0]  last_rx;
    logic [AW:0] fill;
    logic        overflow;

    modport slave (
        input  rx_data, rx_busy, tx_busy,
        output tx_data, tx_wr, last_rx, fill, overflow
    );

    modport master (
        output rx_data, rx_busy, tx_busy,
        input  tx_data, tx_wr, last_rx, fill, overflow
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
// Byte FIFO with an occupancy counter; synchronous active-low reset clears
// pointers and count (storage is not cleared, its contents are unreachable).
//   clk, reset : clock, synchronous active-low reset
//   push_i/din_i  : write request and byte; ignored when full unless popping
//   pop_i/dout_o  : read request; dout_o shows the head entry combinationally
//   fill_o        : occupancy 0..DEPTH
//   full_o/empty_o: status flags
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  byte_t       din_i,
    output byte_t       dout_o,
    output logic [AW:0] fill_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    // A pop in the same cycle frees the slot, so a push at full is accepted.
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign dout_o  = mem_q[rptr_q];
    assign fill_o  = count_q;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + AW'(1);
            if (rd_en) rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl
// Echo path between uart receiver and transmitter: captures each received
// byte on the falling edge of rx_busy into a FIFO and drains it into the
// transmitter with a tx_wr strobe, re-strobing if tx_busy never rises.
//   clk, reset : clock, synchronous active-low reset
//   bus        : uart_echo_ctrl_if.slave (rx_data, rx_busy, tx_busy in;
//                tx_data, tx_wr, last_rx, fill, overflow out)
// Build option UART_ECHO_CRLF_EN: insert 0x0A after every transmitted 0x0D.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a queued byte (or pending LF) and tx idle
// STROBE    | tx_data loaded; pop FIFO; tx_wr pulses next cycle
// WAIT_ACK  | down-counting for tx_busy to rise
// RETRY     | no ack in time; re-strobe same byte, no pop
// WAIT_DONE | transmitter busy; wait for it to finish
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ACK_WAIT = 4
) (
    input logic             clk,
    input logic             reset,
    uart_echo_ctrl_if.slave bus
);

    localparam int CW = $clog2(ACK_WAIT + 1);

    tx_state_e     state_q, state_d;
    byte_t         tx_data_q, tx_data_d;
    byte_t         last_rx_q;
    logic [CW-1:0] ack_cnt_q, ack_cnt_d;
    logic          tx_wr_q, rx_busy_q, overflow_q;
    logic          push, pop;
    byte_t         fifo_dout;
    logic [AW:0]   fifo_fill;
    logic          fifo_full, fifo_empty;
`ifdef UART_ECHO_CRLF_EN
    logic          crlf_pend_q, crlf_pend_d;
    logic          ins_q, ins_d;  // current strobe is an inserted LF
`endif

    assign push = rx_busy_q && !bus.rx_busy;

    uart_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.rx_data),
        .dout_o  (fifo_dout),
        .fill_o  (fifo_fill),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        ack_cnt_d = ack_cnt_q;
        pop       = 1'b0;
`ifdef UART_ECHO_CRLF_EN
        crlf_pend_d = crlf_pend_q;
        ins_d       = ins_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
                    if (crlf_pend_q) begin
                        state_d     = STROBE;
                        tx_data_d   = ASCII_LF;
                        crlf_pend_d = 1'b0;
                        ins_d       = 1'b1;
                    end else if (!fifo_empty) begin
                        state_d   = STROBE;
                        tx_data_d = fifo_dout;
                        ins_d     = 1'b0;
                    end
`else
                    if (!fifo_empty) begin
                        state_d   = STROBE;
                        tx_data_d = fifo_dout;
                    end
`endif
                end
            end
            STROBE: begin
`ifdef UART_ECHO_CRLF_EN
                pop = !ins_q;
`else
                pop = 1'b1;
`endif
                ack_cnt_d = CW'(ACK_WAIT);
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy)
                    state_d = WAIT_DONE;
                else if (ack_cnt_q == '0)
                    state_d = RETRY;
                else
                    ack_cnt_d = ack_cnt_q - CW'(1);
            end
            RETRY: begin
                ack_cnt_d = CW'(ACK_WAIT);
                state_d   = WAIT_ACK;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
`ifdef UART_ECHO_CRLF_EN
                    if (!ins_q && tx_data_q == ASCII_CR) crlf_pend_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_wr_q    <= 1'b0;
            ack_cnt_q  <= '0;
            rx_busy_q  <= 1'b0;
            last_rx_q  <= '0;
            overflow_q <= 1'b0;
`ifdef UART_ECHO_CRLF_EN
            crlf_pend_q <= 1'b0;
            ins_q       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            ack_cnt_q <= ack_cnt_d;
            rx_busy_q <= bus.rx_busy;
            // Strobe lags the STROBE/RETRY state by one cycle so tx_data is
            // already settled when the transmitter latches it.
            tx_wr_q   <= (state_q == STROBE) || (state_q == RETRY);
            if (push) begin
                last_rx_q <= bus.rx_data;
                if (fifo_full && !pop) overflow_q <= 1'b1;
            end
`ifdef UART_ECHO_CRLF_EN
            crlf_pend_q <= crlf_pend_d;
            ins_q       <= ins_d;
`endif
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wr    = tx_wr_q;
    assign bus.last_rx  = last_rx_q;
    assign bus.fill     = fifo_fill;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
module tb_uart_echo_ctrl;
    import uart_pkg::*;

    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int ACK_WAIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_echo_ctrl_if #(.AW(AW)) bus();

    uart_echo_ctrl #(.DEPTH(DEPTH), .AW(AW), .ACK_WAIT(ACK_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        byte_t rx;
        byte_t exp_tx;
        int    exp_lat;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    busy_mode = 0;
    int    consec  = 0;
    logic  prev_wr = 1'b0;
    byte_t txq[$];
    int    tcq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every tx_wr pulse with its data and cycle stamp.
    initial forever begin
        @(negedge clk);
        if (bus.tx_wr === 1'b1) begin
            txq.push_back(bus.tx_data);
            tcq.push_back(cyc);
            if (prev_wr) consec++;
        end
        prev_wr = bus.tx_wr;
    end

    // Transmitter model: busy rises 2 cycles after tx_wr and lasts 10 cycles.
    initial forever begin
        @(negedge clk);
        if (busy_mode == 1 && bus.tx_wr === 1'b1) begin
            repeat (2) @(posedge clk);
            #1 bus.tx_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One frame: rx_busy high one cycle, then low; returns the cycle stamp
    // of the fall. Ends #1 after the edge that performs the push.
    task automatic send_byte(input byte_t b, output int t_fall);
        @(posedge clk);
        #1 bus.rx_data = b;
        bus.rx_busy = 1'b1;
        @(posedge clk);
        #1 bus.rx_busy = 1'b0;
        t_fall = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_txq(input int n, input int maxc, input string name);
        int k = 0;
        while (txq.size() < n && k < maxc) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, int'(txq.size() >= n), 1);
    endtask

    vec_t  vecs[4];
    byte_t exp_seq[$];
    int    t0, tdummy;

    initial begin
        vecs[0] = '{8'h41, 8'h41, 3};
        vecs[1] = '{8'h00, 8'h00, 3};
        vecs[2] = '{8'hFF, 8'hFF, 3};
        vecs[3] = '{8'h5A, 8'h5A, 3};

        bus.rx_data = 8'h00;
        bus.rx_busy = 1'b0;
        bus.tx_busy = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_tx_wr",    bus.tx_wr,    0);
        check("rst_tx_data",  bus.tx_data,  0);
        check("rst_last_rx",  bus.last_rx,  0);
        check("rst_fill",     bus.fill,     0);
        check("rst_overflow", bus.overflow, 0);

        // Single-byte echo vectors
        busy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            txq.delete();
            tcq.delete();
            send_byte(vecs[i].rx, t0);
            check("vec_last_rx", bus.last_rx, vecs[i].rx);
            check("vec_fill_after_push", bus.fill, 1);
            wait_txq(1, 20, "vec_tx_wr_seen");
            if (txq.size() > 0) begin
                check("vec_tx_data", txq[0], vecs[i].exp_tx);
                check("vec_latency", tcq[0] - t0, vecs[i].exp_lat);
            end
            repeat (25) @(posedge clk);
            #1;
            check("vec_single_pulse", txq.size(), 1);
            check("vec_fill_drained", bus.fill, 0);
        end

        // Burst to full, then overflow, then drain in order
        busy_mode = 0;
        bus.tx_busy = 1'b1;
        txq.delete();
        for (int i = 0; i < 8; i++) send_byte(byte_t'(8'h30 + i), tdummy);
        check("burst_fill8", bus.fill, 8);
        check("burst_no_ovf", bus.overflow, 0);
        send_byte(8'h38, tdummy);
        check("ovf_set", bus.overflow, 1);
        check("ovf_fill8", bus.fill, 8);
        check("ovf_last_rx", bus.last_rx, 8'h38);
        check("burst_no_tx_while_busy", txq.size(), 0);
        busy_mode = 1;
        bus.tx_busy = 1'b0;
        wait_txq(8, 400, "burst_drain_seen");
        repeat (30) @(posedge clk);
        #1;
        check("burst_drain_count", txq.size(), 8);
        for (int i = 0; i < 8 && i < txq.size(); i++)
            check("burst_order", txq[i], 8'h30 + i);
        check("burst_fill0", bus.fill, 0);
        check("ovf_sticky", bus.overflow, 1);

        // Retry: tx_busy never rises
        busy_mode = 0;
        bus.tx_busy = 1'b0;
        txq.delete();
        tcq.delete();
        send_byte(8'h77, t0);
        send_byte(8'h78, tdummy);
        wait_txq(4, 60, "retry_pulses_seen");
        if (txq.size() >= 4) begin
            check("retry_first_latency", tcq[0] - t0, 3);
            for (int i = 0; i < 4; i++) check("retry_data", txq[i], 8'h77);
            for (int i = 1; i < 4; i++)
                check("retry_period", tcq[i] - tcq[i-1], ACK_WAIT + 2);
        end
        check("retry_fill_unchanged", bus.fill, 1);

        // Reset mid-transfer with fill=3
        send_byte(8'h79, tdummy);
        send_byte(8'h7A, tdummy);
        check("pre_reset_fill3", bus.fill, 3);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_tx_wr", bus.tx_wr, 0);
        check("midrst_fill", bus.fill, 0);
        reset = 1'b1;
        txq.delete();
        tcq.delete();
        check("midrst_tx_data", bus.tx_data, 0);
        check("midrst_last_rx", bus.last_rx, 0);
        check("midrst_overflow", bus.overflow, 0);
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_tx_after", txq.size(), 0);

        // Push coincident with STROBE pop at full
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(byte_t'(8'h10 + i), tdummy);
        check("coinc_fill8", bus.fill, 8);
        txq.delete();
        @(posedge clk);
        #1 bus.tx_busy = 1'b0;
        busy_mode = 1;
        bus.rx_data = 8'h18;
        bus.rx_busy = 1'b1;
        @(posedge clk);
        #1 bus.rx_busy = 1'b0;
        @(posedge clk);
        #1;
        check("coinc_fill_stays8", bus.fill, 8);
        check("coinc_no_ovf", bus.overflow, 0);
        check("coinc_last_rx", bus.last_rx, 8'h18);
        wait_txq(9, 400, "coinc_drain_seen");
        repeat (30) @(posedge clk);
        #1;
        check("coinc_drain_count", txq.size(), 9);
        for (int i = 0; i < 9 && i < txq.size(); i++)
            check("coinc_order", txq[i], 8'h10 + i);

        // CR handling
`ifdef UART_ECHO_CRLF_EN
        exp_seq = '{8'h0D, 8'h0A, 8'h41};
`else
        exp_seq = '{8'h0D, 8'h41};
`endif
        txq.delete();
        send_byte(8'h0D, tdummy);
        send_byte(8'h41, tdummy);
        wait_txq(exp_seq.size(), 200, "crlf_seen");
        repeat (40) @(posedge clk);
        #1;
        check("crlf_count", txq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < txq.size(); i++)
            check("crlf_seq", txq[i], exp_seq[i]);
        check("crlf_fill0", bus.fill, 0);

        check("no_back_to_back_tx_wr", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
